// File: rtl/i2c_master_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_master_ctrl_if : host command/response bundle of the I2C master      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface i2c_master_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       rd_nack;
    logic       cmd_ready;
    logic       done;
    logic       ack_n;
    logic [7:0] rx_data;
    logic       cmd_err;
    logic       bus_held;

    modport master (
        output cmd_valid, cmd, tx_data, rd_nack,
        input  cmd_ready, done, ack_n, rx_data, cmd_err, bus_held
    );

    modport slave (
        input  cmd_valid, cmd, tx_data, rd_nack,
        output cmd_ready, done, ack_n, rx_data, cmd_err, bus_held
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_master_ctrl : byte-level single-master I2C engine with stretching    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_master_ctrl #(
    parameter int QTR_CYCLES = 125
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    i2c_master_ctrl_if.slave  host,
    inout  wire               io_scl,
    inout  wire               io_sda
);
    localparam int              c_CW       = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(QTR_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SYNC_LAT = c_CW'(2);
    localparam logic [1:0]      c_CMD_START = 2'b00;
    localparam logic [1:0]      c_CMD_WRITE = 2'b01;
    localparam logic [1:0]      c_CMD_READ  = 2'b10;
    localparam logic [1:0]      c_CMD_STOP  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_qtr;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit;
    logic [1:0]      r_cmd;
    logic [7:0]      r_tx;
    logic            r_nack;
    logic [7:0]      r_shift;
    logic            r_ack_smp;
    logic            r_ack_n;
    logic [7:0]      r_rx;
    logic            r_done;
    logic            r_err;
    logic            r_bus_held;
    logic            r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;

    logic w_accept, w_reject, w_finish;
    logic w_cnt_adv, w_qtr_end, w_step_end;
    logic w_scl_low, w_sda_low;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_finish    = 1'b0;
        w_scl_low   = 1'b0;
        w_sda_low   = 1'b0;
        // q1 covers the synchronizer latency, then freezes until SCL is seen high
        w_cnt_adv   = !((r_state != S_IDLE) && (r_qtr == 2'd1) &&
                        (r_cnt >= c_SYNC_LAT) && !r_scl_s2);
        w_qtr_end   = (r_state != S_IDLE) && w_cnt_adv && (r_cnt == c_CNT_MAX);
        w_step_end  = w_qtr_end && (r_qtr == 2'd3);

        case (r_state)
            S_IDLE: begin
                w_scl_low = r_bus_held;
                if (host.cmd_valid) begin
                    if (host.cmd == c_CMD_START) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_START;
                    end else if (!r_bus_held) begin
                        w_reject    = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (host.cmd == c_CMD_STOP) ? S_STOP : S_BIT;
                    end
                end
            end
            S_START: begin
                w_scl_low = ((r_qtr == 2'd0) && r_bus_held) || (r_qtr == 2'd3);
                w_sda_low = r_qtr[1];
                if (w_step_end) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BIT: begin
                w_scl_low = (r_qtr == 2'd0) || (r_qtr == 2'd3);
                if (r_bit == 4'd8)
                    w_sda_low = (r_cmd == c_CMD_READ) && !r_nack;
                else
                    w_sda_low = (r_cmd == c_CMD_WRITE) && !r_tx[7];
                if (w_step_end && (r_bit == 4'd8)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_STOP: begin
                w_scl_low = (r_qtr == 2'd0);
                w_sda_low = !r_qtr[1];
                if (w_step_end) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qtr      <= 2'd0;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_cmd      <= 2'b00;
            r_tx       <= 8'h00;
            r_nack     <= 1'b0;
            r_shift    <= 8'h00;
            r_ack_smp  <= 1'b1;
            r_ack_n    <= 1'b1;
            r_rx       <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bus_held <= 1'b0;
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
        end else begin
            r_scl_s1 <= io_scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= io_sda;
            r_sda_s2 <= r_sda_s1;
            r_done   <= w_finish;
            r_err    <= w_reject;

            if (w_accept) begin
                r_cmd  <= host.cmd;
                r_tx   <= host.tx_data;
                r_nack <= host.rd_nack;
                r_qtr  <= 2'd0;
                r_cnt  <= '0;
                r_bit  <= 4'd0;
            end else if ((r_state != S_IDLE) && w_cnt_adv) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_cnt <= '0;
                    r_qtr <= r_qtr + 2'd1;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end

            if ((r_state == S_BIT) && w_qtr_end && (r_qtr == 2'd1)) begin
                if (r_bit == 4'd8)
                    r_ack_smp <= r_sda_s2;
                else if (r_cmd == c_CMD_READ)
                    r_shift <= {r_shift[6:0], r_sda_s2};
            end

            if ((r_state == S_BIT) && w_step_end) begin
                r_bit <= r_bit + 4'd1;
                r_tx  <= {r_tx[6:0], 1'b0};
            end

            if (w_finish) begin
                case (r_state)
                    S_START: r_bus_held <= 1'b1;
                    S_STOP:  r_bus_held <= 1'b0;
                    S_BIT: begin
                        if (r_cmd == c_CMD_WRITE) r_ack_n <= r_ack_smp;
                        else                      r_rx    <= r_shift;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign host.cmd_ready = (r_state == S_IDLE);
    assign host.done      = r_done;
    assign host.ack_n     = r_ack_n;
    assign host.rx_data   = r_rx;
    assign host.cmd_err   = r_err;
    assign host.bus_held  = r_bus_held;

    assign io_scl = w_scl_low ? 1'b0 : 1'bz;
    assign io_sda = w_sda_low ? 1'b0 : 1'bz;
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_master_ctrl : randomized bench with I2C slave and command model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_i2c_master_ctrl;
    localparam int         Q       = 125;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;
    localparam int         M_OFF   = 0;
    localparam int         M_WACK  = 1;
    localparam int         M_WNAK  = 2;
    localparam int         M_READ  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    wire scl_w;
    wire sda_w;
    pullup (scl_w);
    pullup (sda_w);

    i2c_master_ctrl_if bus_if ();

    i2c_master_ctrl #(.QTR_CYCLES(Q)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .host   (bus_if.slave),
        .io_scl (scl_w),
        .io_sda (sda_w)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: reacts to SCL edges seen on clk, open-drain pulls only
    int         sl_mode    = M_OFF;
    logic [7:0] sl_byte    = 8'h00;
    int         sl_go      = 0;
    int         sl_go_seen = 0;
    int         sl_cnt     = 0;
    logic       sl_drive   = 1'b0;
    logic [7:0] sl_cap     = 8'h00;
    logic       sl_mack    = 1'b0;
    logic       p_scl      = 1'b1;
    logic       p_sda      = 1'b1;
    int         n_start    = 0;
    int         n_stop     = 0;
    logic       tb_scl_low = 1'b0;

    assign scl_w = tb_scl_low ? 1'b0 : 1'bz;
    assign sda_w = (sl_drive && (sl_mode != M_OFF)) ? 1'b0 : 1'bz;

    always @(posedge clk) begin
        if (sl_go != sl_go_seen) begin
            sl_go_seen <= sl_go;
            sl_cnt     <= 0;
            sl_cap     <= 8'h00;
            sl_drive   <= (sl_mode == M_READ) ? ~sl_byte[7] : 1'b0;
        end else begin
            if (!p_scl && scl_w) begin
                sl_cnt <= sl_cnt + 1;
                if (sl_cnt < 8)  sl_cap  <= {sl_cap[6:0], sda_w};
                if (sl_cnt == 8) sl_mack <= sda_w;
            end
            if (p_scl && !scl_w) begin
                if (sl_mode == M_WACK)
                    sl_drive <= (sl_cnt == 8);
                else if (sl_mode == M_READ)
                    sl_drive <= (sl_cnt < 8) ? ~sl_byte[7 - sl_cnt] : 1'b0;
            end
            if (p_scl && scl_w && p_sda && !sda_w) n_start <= n_start + 1;
            if (p_scl && scl_w && !p_sda && sda_w) n_stop  <= n_stop + 1;
        end
        p_scl <= scl_w;
        p_sda <= sda_w;
    end

    // Reference model of the host-visible state
    logic       exp_held = 1'b0;
    logic       exp_ack  = 1'b1;
    logic [7:0] exp_rx   = 8'h00;

    task automatic check_outputs(input string tag);
        chk({tag, "_held"}, bus_if.bus_held, exp_held);
        chk({tag, "_ackn"}, bus_if.ack_n,    exp_ack);
        chk({tag, "_rx"},   bus_if.rx_data,  exp_rx);
    endtask

    // Issue one legal command; stretch holds SCL low from q0 of step st_step
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic nack,
                           input logic acked, input int st_step, input int st_len);
        int   lat;
        int   exp_lat;
        int   s0;
        int   p0;
        logic seen;
        exp_lat = (c == C_START || c == C_STOP) ? 4 * Q : 36 * Q;
        if (st_len > Q) exp_lat = exp_lat + st_len - Q;
        case (c)
            C_WRITE: sl_mode = acked ? M_WACK : M_WNAK;
            C_READ:  sl_mode = M_READ;
            default: sl_mode = M_OFF;
        endcase
        sl_byte = d;
        sl_go   = sl_go + 1;
        s0      = n_start;
        p0      = n_stop;
        chk("ready_before", bus_if.cmd_ready, 1'b1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd       = c;
        bus_if.tx_data   = d;
        bus_if.rd_nack   = nack;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.tx_data   = 8'($urandom);
        bus_if.rd_nack   = 1'($urandom);
        chk("ready_drop", bus_if.cmd_ready, 1'b0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < exp_lat + 300) begin
            if (st_len > 0 && lat == 4 * Q * st_step)          tb_scl_low = 1'b1;
            if (st_len > 0 && lat == 4 * Q * st_step + st_len) tb_scl_low = 1'b0;
            @(posedge clk); #1;
            lat++;
            seen = bus_if.done;
        end
        tb_scl_low = 1'b0;
        chk("latency", lat, exp_lat);
        chk("ready_at_done", bus_if.cmd_ready, 1'b1);
        case (c)
            C_START: begin
                exp_held = 1'b1;
                chk("start_cond", n_start - s0, 1);
            end
            C_STOP: begin
                exp_held = 1'b0;
                chk("stop_cond", n_stop - p0, 1);
            end
            C_WRITE: begin
                exp_ack = !acked;
                chk("wr_bits", sl_cap, d);
            end
            default: begin
                exp_rx = d;
                chk("rd_master_ack", sl_mack, nack);
            end
        endcase
        check_outputs("post");
        @(posedge clk); #1;
        chk("done_one_cycle", bus_if.done, 1'b0);
    endtask

    task automatic run_bad(input logic [1:0] c);
        int bad;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd       = c;
        bus_if.tx_data   = 8'($urandom);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        chk("err_pulse", bus_if.cmd_err, 1'b1);
        chk("err_ready", bus_if.cmd_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.done || scl_w !== 1'b1 || sda_w !== 1'b1) bad++;
            @(posedge clk); #1;
            if (bus_if.cmd_err) bad++;
        end
        chk("err_quiet", bad, 0);
        check_outputs("err");
    endtask

    initial begin
        int         idle_bad;
        logic [7:0] rb;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd       = 2'b00;
        bus_if.tx_data   = 8'h00;
        bus_if.rd_nack   = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_ready", bus_if.cmd_ready, 1'b1);
        chk("rst_done",  bus_if.done,      1'b0);
        chk("rst_err",   bus_if.cmd_err,   1'b0);
        check_outputs("rst");
        rst_n = 1'b1;

        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (scl_w !== 1'b1 || sda_w !== 1'b1 || !bus_if.cmd_ready ||
                bus_if.bus_held || bus_if.done) idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);

        run_bad(C_WRITE);
        run_bad(C_READ);
        run_bad(C_STOP);

        run_cmd(C_START, 8'h00, 1'b0, 1'b0, 0, 0);
        run_cmd(C_WRITE, 8'h4E, 1'b0, 1'b1, 0, 0);
        run_cmd(C_READ,  8'hA5, 1'b1, 1'b0, 0, 0);
        run_cmd(C_STOP,  8'h00, 1'b0, 1'b0, 0, 0);
        chk("stop_scl", scl_w, 1'b1);
        chk("stop_sda", sda_w, 1'b1);

        run_cmd(C_START, 8'h00, 1'b0, 1'b0, 0, 0);
        run_cmd(C_WRITE, 8'($urandom), 1'b0, 1'b0, 0, 0);
        run_cmd(C_START, 8'h00, 1'b0, 1'b0, 0, 0);
        run_cmd(C_WRITE, 8'h3C, 1'b0, 1'b1, 4, 2000);
        run_cmd(C_STOP,  8'h00, 1'b0, 1'b0, 0, 0);

        run_cmd(C_START, 8'h00, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                run_cmd(C_WRITE, rb, 1'b0, 1'($urandom_range(0, 1)), 0, 0);
            else
                run_cmd(C_READ, rb, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
        end
        run_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 0, 0);

        run_cmd(C_START, 8'h00, 1'b0, 1'b0, 0, 0);
        sl_mode = M_READ;
        sl_byte = 8'h00;
        sl_go   = sl_go + 1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd       = C_READ;
        bus_if.rd_nack   = 1'b0;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        repeat (1000) @(posedge clk);
        #3;
        sl_mode = M_OFF;
        rst_n   = 1'b0;
        #1;
        exp_held = 1'b0;
        exp_ack  = 1'b1;
        exp_rx   = 8'h00;
        chk("rst_mid_scl",   scl_w, 1'b1);
        chk("rst_mid_sda",   sda_w, 1'b1);
        chk("rst_mid_ready", bus_if.cmd_ready, 1'b1);
        chk("rst_mid_done",  bus_if.done, 1'b0);
        check_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Byte-level I2C bus master; the initiator end of the link served by the I2C slave (LCD/buttons/rotary board).
- Accepts one command at a time from the host logic: START (incl. repeated start), WRITE byte, READ byte, STOP.
- Drives the open-drain scl/sda pins and returns the ACK bit and read data.
- Single master only, no arbitration. Supports slave clock stretching.

Parameters:
- QTR_CYCLES, 125, clk cycles per quarter SCL period (50 MHz clk -> 100 kHz SCL); must be >= 4.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request; sampled when cmd_ready=1.
- cmd  input  2  00 START, 01 WRITE, 10 READ, 11 STOP.
- tx_data  input  8  byte for WRITE, captured with the command.
- rd_nack  input  1  for READ: 1 = master sends NACK after the byte (last byte), 0 = ACK; captured with the command.
- cmd_ready  output  1  engine idle, can accept a command.
- done  output  1  one-cycle pulse when a command completes.
- ack_n  output  1  SDA level sampled in the 9th bit of the last WRITE (0 = slave ACK); holds until the next WRITE completes.
- rx_data  output  8  byte from the last READ, MSB first; holds until the next READ completes.
- cmd_err  output  1  one-cycle pulse; command rejected.
- bus_held  output  1  1 between a completed START and a completed STOP.
- scl  inout  1  open drain: drive 0 or high-Z, never drive 1.
- sda  inout  1  open drain: drive 0 or high-Z, never drive 1.

Behaviour:
- Reset (reset=0, async): scl and sda high-Z, state IDLE, quarter counter 0.
  - cmd_ready=1, done=0, cmd_err=0, bus_held=0, ack_n=1, rx_data=8'h00.
  - Reset mid-transfer releases both lines immediately. No STOP is generated.
- Input sync: scl and sda pass through 2-flop synchronizers before any use.
- Handshake:
  - A command is accepted on the rising clk edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready drops the next cycle and rises in the same cycle as done.
  - cmd, tx_data and rd_nack are registered at acceptance.
- Timing:
  - Every bit-level step is 4 quarters, q0..q3, each QTR_CYCLES clocks.
  - q1 (SCL released) does not end until synced scl=1, then runs its full QTR_CYCLES. This is clock stretching; no timeout.
- States: IDLE, START, BIT, STOP. BIT runs 9 times for WRITE/READ, bit index 7..0 then the ACK slot.
- START (4 quarters): q0 release SDA; q1 release SCL; q2 drive SDA 0; q3 drive SCL 0. Then set bus_held=1 and pulse done.
  - START with bus_held=1 is a repeated start; same sequence.
- WRITE data bit:
  - q0 drive SDA = tx bit (0 -> drive low, 1 -> release); q1 release SCL; q2 hold; q3 drive SCL 0.
  - ACK slot: SDA released in q0; synced sda sampled at the q1->q2 boundary into ack_n.
- READ:
  - Data bits: SDA released; synced sda sampled at the q1->q2 boundary, shifted in MSB first.
  - ACK slot: master drives SDA = rd_nack.
  - rx_data updates on done.
- STOP: q0 drive SDA 0; q1 release SCL; q2 release SDA; q3 idle. Then bus_held=0 and pulse done.
- Command latency at QTR_CYCLES=Q, no stretching: START/STOP = 4Q clocks; WRITE/READ = 36Q clocks (4500 at default), acceptance to done.
- Illegal commands: WRITE, READ or STOP with bus_held=0.
  - cmd_err pulses one cycle after acceptance and done does not pulse.
  - cmd_ready returns 1 in that same cycle; bus untouched.
- SDA changes only while SCL is driven low, except the START q2 and STOP q2 edges.
- A NACK on WRITE does not abort. Host decides; typically it issues STOP.

Test Plan:
- Reset released, no commands for 1000 cycles -> scl/sda stay high (pullups), cmd_ready=1, bus_held=0, no done.
- START, then WRITE 8'h4E to a slave model that ACKs -> SDA falls while SCL is high; 8 SCL pulses carry 0,1,0,0,1,1,1,0; ack_n=0.
  - done at 500 and 4500 clocks after each acceptance; bus_held=1.
- READ with rd_nack=1, slave returns 8'hA5 -> rx_data=8'hA5; master releases SDA on the 9th clock.
  - Then STOP -> SDA rises while SCL is high; bus_held=0.
- WRITE with no slave responding (SDA floats high) -> ack_n=1, done pulses, bus_held stays 1.
  - Repeated START then STOP complete normally.
- Slave holds SCL low 2000 clocks at bit 3 of a WRITE -> q1 extends.
  - done delayed by exactly the stretch duration minus the unstretched synchronized wait; data still correct.
- WRITE issued with bus_held=0 -> cmd_err pulse one cycle after acceptance, scl/sda untouched.
  - Separately, assert reset mid-READ -> both lines high-Z within the same cycle, outputs at reset values.
